// File: rtl/spoc_bdo_packer.sv
// rtl/spoc_bdo_packer.sv - SpoC-64 bdo output packer: byte masking, FIFO, segment drain FSM (optional SPOC_BDO_ZEROIZE_EN)
module spoc_bdo_packer #(
    parameter int PW    = 32,
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PW-1:0]            in_data,
    input  logic [2:0]               in_size,
    input  logic                     in_last,
    input  logic                     in_tag,
    output logic                     bdo_valid,
    input  logic                     bdo_ready,
    output logic [PW-1:0]            bdo_data,
    output logic [PW/8-1:0]          bdo_valid_bytes,
    output logic                     bdo_last,
    output logic                     bdo_is_tag,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [CW-1:0]            word_count
);

    localparam int NB = PW / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam logic [FW-1:0] FULL = FW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

    typedef struct packed {
        logic [PW-1:0] data;
        logic [NB-1:0] be;
        logic          last;
        logic          tag;
    } entry_t;

    state_t          state_q, state_d;
    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic [CW-1:0]   wc_q, wc_d;
    logic            in_ready_q, in_ready_d;

    logic [PW-1:0]   in_masked;
    logic [NB-1:0]   in_be;
    entry_t          head;
    logic            push;
    logic            pop;
    int              size_k;

    // Zero the trailing bytes of a partial word; out-of-range sizes mean a full word.
    always_comb begin
        in_masked = '0;
        in_be     = '0;
        size_k    = int'(in_size);
        if (size_k == 0 || size_k > NB) begin
            size_k = NB;
        end
        for (int i = 0; i < NB; i++) begin
            if (i < size_k) begin
                in_be[NB-1-i]             = 1'b1;
                in_masked[PW-1-8*i -: 8]  = in_data[PW-1-8*i -: 8];
            end
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign bdo_valid = (fill_q != '0);
    assign push      = in_valid & in_ready_q;
    assign pop       = bdo_valid & bdo_ready;

    // Next-state for FIFO, pointers, segment FSM, word counter and registered in_ready.
    always_comb begin
        state_d  = state_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        wc_d     = wc_q;
        if (flush) begin
            state_d  = S_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
            wc_d     = '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{data: in_masked, be: in_be, last: in_last, tag: in_tag};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
`ifdef SPOC_BDO_ZEROIZE_EN
                mem_d[rd_ptr_q] = '0;
`endif
                rd_ptr_d = rd_ptr_q + 1'b1;
                if (head.last) begin
                    wc_d = '0;
                end else if (wc_q != '1) begin
                    wc_d = wc_q + 1'b1;
                end
            end
            if (push && !pop) begin
                fill_d = fill_q + 1'b1;
            end else if (pop && !push) begin
                fill_d = fill_q - 1'b1;
            end
            case (state_q)
                S_IDLE:   if (push) state_d = in_last ? S_DRAIN : S_STREAM;
                S_STREAM: if (push && in_last) state_d = S_DRAIN;
                S_DRAIN:  if (pop && head.last) state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
        case (state_d)
            S_IDLE:   in_ready_d = 1'b1;
            S_STREAM: in_ready_d = (fill_d < FULL);
            default:  in_ready_d = 1'b0;
        endcase
    end

    // State registers; reset discards every buffered word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            wc_q       <= '0;
            in_ready_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            wc_q       <= wc_d;
            in_ready_q <= in_ready_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign in_ready        = in_ready_q;
    assign fill            = fill_q;
    assign word_count      = wc_q;
    assign bdo_valid_bytes = bdo_valid ? head.be : '0;
    assign bdo_last        = bdo_valid & head.last;
    assign bdo_is_tag      = bdo_valid & head.tag;
`ifdef SPOC_BDO_ZEROIZE_EN
    assign bdo_data        = bdo_valid ? head.data : '0;
`else
    assign bdo_data        = head.data;
`endif

endmodule

// File: tb/tb_spoc_bdo_packer.sv
// tb/tb_spoc_bdo_packer.sv - directed self-checking bench for spoc_bdo_packer
module tb_spoc_bdo_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [2:0]  in_size;
    logic        in_last;
    logic        in_tag;
    logic        bdo_valid;
    logic        bdo_ready;
    logic [31:0] bdo_data;
    logic [3:0]  bdo_valid_bytes;
    logic        bdo_last;
    logic        bdo_is_tag;
    logic [2:0]  fill;
    logic [15:0] word_count;

    int n_checks = 0;
    int n_fail   = 0;

    spoc_bdo_packer #(.PW(32), .DEPTH(4), .CW(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_size         (in_size),
        .in_last         (in_last),
        .in_tag          (in_tag),
        .bdo_valid       (bdo_valid),
        .bdo_ready       (bdo_ready),
        .bdo_data        (bdo_data),
        .bdo_valid_bytes (bdo_valid_bytes),
        .bdo_last        (bdo_last),
        .bdo_is_tag      (bdo_is_tag),
        .fill            (fill),
        .word_count      (word_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic [2:0] s, input logic l, input logic t);
        in_valid = 1'b1;
        in_data  = d;
        in_size  = s;
        in_last  = l;
        in_tag   = t;
    endtask

    task automatic idle_in;
        in_valid = 1'b0;
        in_data  = '0;
        in_size  = '0;
        in_last  = 1'b0;
        in_tag   = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; flush = 1'b0; bdo_ready = 1'b0;
        idle_in();
        #12;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_checks++; if (bdo_valid !== 1'b0) begin n_fail++; $display("FAIL rst_bdo_valid: got %b want 0", bdo_valid); end
        n_checks++; if (fill !== 3'd0) begin n_fail++; $display("FAIL rst_fill: got %0d want 0", fill); end
        n_checks++; if (bdo_data !== 32'h0) begin n_fail++; $display("FAIL rst_bdo_data: got %h want 0", bdo_data); end
        n_checks++; if (word_count !== 16'd0) begin n_fail++; $display("FAIL rst_word_count: got %0d want 0", word_count); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single;
        bdo_ready = 1'b1;
        drive(32'hDEADBEEF, 3'd4, 1'b1, 1'b0);
        tick();
        idle_in();
        n_checks++; if (bdo_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", bdo_valid); end
        n_checks++; if (bdo_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data: got %h want deadbeef", bdo_data); end
        n_checks++; if (bdo_valid_bytes !== 4'b1111) begin n_fail++; $display("FAIL single_mask: got %b want 1111", bdo_valid_bytes); end
        n_checks++; if (bdo_last !== 1'b1) begin n_fail++; $display("FAIL single_last: got %b want 1", bdo_last); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL single_in_ready_drain: got %b want 0", in_ready); end
        tick();
        n_checks++; if (bdo_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_after: got %b want 0", bdo_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready_after: got %b want 1", in_ready); end
        n_checks++; if (word_count !== 16'd0) begin n_fail++; $display("FAIL single_word_count: got %0d want 0", word_count); end
    endtask

    task automatic test_masking;
        bdo_ready = 1'b1;
        drive(32'h11223344, 3'd1, 1'b0, 1'b0);
        tick();
        n_checks++; if (bdo_data !== 32'h11000000) begin n_fail++; $display("FAIL mask1_data: got %h want 11000000", bdo_data); end
        n_checks++; if (bdo_valid_bytes !== 4'b1000) begin n_fail++; $display("FAIL mask1_be: got %b want 1000", bdo_valid_bytes); end
        drive(32'h11223344, 3'd3, 1'b1, 1'b0);
        tick();
        idle_in();
        n_checks++; if (bdo_data !== 32'h11223300) begin n_fail++; $display("FAIL mask3_data: got %h want 11223300", bdo_data); end
        n_checks++; if (bdo_valid_bytes !== 4'b1110) begin n_fail++; $display("FAIL mask3_be: got %b want 1110", bdo_valid_bytes); end
        n_checks++; if (word_count !== 16'd1) begin n_fail++; $display("FAIL mask_word_count: got %0d want 1", word_count); end
        tick();
        n_checks++; if (fill !== 3'd0) begin n_fail++; $display("FAIL mask_fill_end: got %0d want 0", fill); end
        n_checks++; if (word_count !== 16'd0) begin n_fail++; $display("FAIL mask_wc_end: got %0d want 0", word_count); end
    endtask

    task automatic test_size_clamp;
        bdo_ready = 1'b1;
        drive(32'hCAFEF00D, 3'd0, 1'b0, 1'b0);
        tick();
        n_checks++; if (bdo_valid_bytes !== 4'b1111) begin n_fail++; $display("FAIL size0_be: got %b want 1111", bdo_valid_bytes); end
        n_checks++; if (bdo_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL size0_data: got %h want cafef00d", bdo_data); end
        drive(32'h01020304, 3'd7, 1'b1, 1'b0);
        tick();
        idle_in();
        n_checks++; if (bdo_valid_bytes !== 4'b1111) begin n_fail++; $display("FAIL size7_be: got %b want 1111", bdo_valid_bytes); end
        n_checks++; if (bdo_data !== 32'h01020304) begin n_fail++; $display("FAIL size7_data: got %h want 01020304", bdo_data); end
        tick();
    endtask

    task automatic test_backpressure;
        logic [31:0] w [5];
        for (int i = 0; i < 5; i++) w[i] = 32'hB0000000 + 32'(i);
        bdo_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(w[i], 3'd4, 1'b0, 1'b0);
            tick();
        end
        n_checks++; if (fill !== 3'd4) begin n_fail++; $display("FAIL bp_fill_full: got %0d want 4", fill); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full: got %b want 0", in_ready); end
        drive(w[4], 3'd4, 1'b1, 1'b0);
        tick();
        n_checks++; if (fill !== 3'd4) begin n_fail++; $display("FAIL bp_stall_fill: got %0d want 4", fill); end
        n_checks++; if (bdo_data !== w[0]) begin n_fail++; $display("FAIL bp_stall_head: got %h want %h", bdo_data, w[0]); end
        bdo_ready = 1'b1;
        tick();
        n_checks++; if (fill !== 3'd3) begin n_fail++; $display("FAIL bp_fill_after_pop: got %0d want 3", fill); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_reopen: got %b want 1", in_ready); end
        n_checks++; if (bdo_data !== w[1]) begin n_fail++; $display("FAIL bp_order1: got %h want %h", bdo_data, w[1]); end
        tick();
        idle_in();
        n_checks++; if (fill !== 3'd3) begin n_fail++; $display("FAIL bp_fill_pushpop: got %0d want 3", fill); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_drain: got %b want 0", in_ready); end
        n_checks++; if (bdo_data !== w[2]) begin n_fail++; $display("FAIL bp_order2: got %h want %h", bdo_data, w[2]); end
        tick();
        n_checks++; if (bdo_data !== w[3]) begin n_fail++; $display("FAIL bp_order3: got %h want %h", bdo_data, w[3]); end
        tick();
        n_checks++; if (bdo_data !== w[4]) begin n_fail++; $display("FAIL bp_order4: got %h want %h", bdo_data, w[4]); end
        n_checks++; if (bdo_last !== 1'b1) begin n_fail++; $display("FAIL bp_last: got %b want 1", bdo_last); end
        n_checks++; if (word_count !== 16'd4) begin n_fail++; $display("FAIL bp_word_count: got %0d want 4", word_count); end
        tick();
        n_checks++; if (fill !== 3'd0) begin n_fail++; $display("FAIL bp_fill_end: got %0d want 0", fill); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_end: got %b want 1", in_ready); end
        n_checks++; if (word_count !== 16'd0) begin n_fail++; $display("FAIL bp_wc_end: got %0d want 0", word_count); end
    endtask

    task automatic test_back_to_back;
        bdo_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            drive(32'hA0000000 + 32'(k - 1), 3'd4, (k == 8), (k >= 7));
            tick();
            n_checks++; if (bdo_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, bdo_valid); end
            n_checks++; if (bdo_data !== 32'hA0000000 + 32'(k - 1)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", k, bdo_data, 32'hA0000000 + 32'(k - 1)); end
            n_checks++; if (bdo_is_tag !== (k >= 7)) begin n_fail++; $display("FAIL b2b_tag[%0d]: got %b want %b", k, bdo_is_tag, (k >= 7)); end
            n_checks++; if (word_count !== 16'(k - 1)) begin n_fail++; $display("FAIL b2b_wc[%0d]: got %0d want %0d", k, word_count, k - 1); end
            n_checks++; if (fill !== 3'd1) begin n_fail++; $display("FAIL b2b_fill[%0d]: got %0d want 1", k, fill); end
        end
        idle_in();
        tick();
        n_checks++; if (bdo_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_end: got %b want 0", bdo_valid); end
        n_checks++; if (word_count !== 16'd0) begin n_fail++; $display("FAIL b2b_wc_end: got %0d want 0", word_count); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready_end: got %b want 1", in_ready); end
    endtask

    task automatic test_flush;
        bdo_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(32'hF0000000 + 32'(i), 3'd4, 1'b0, 1'b0);
            tick();
        end
        idle_in();
        bdo_ready = 1'b1;
        tick();
        bdo_ready = 1'b0;
        n_checks++; if (word_count !== 16'd1) begin n_fail++; $display("FAIL flush_pre_wc: got %0d want 1", word_count); end
        flush = 1'b1;
        drive(32'h12345678, 3'd4, 1'b0, 1'b0);
        #2;
        n_checks++; if (fill !== 3'd2) begin n_fail++; $display("FAIL flush_pre_fill: got %0d want 2", fill); end
        tick();
        flush = 1'b0;
        idle_in();
        n_checks++; if (fill !== 3'd0) begin n_fail++; $display("FAIL flush_fill: got %0d want 0", fill); end
        n_checks++; if (bdo_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", bdo_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        n_checks++; if (word_count !== 16'd0) begin n_fail++; $display("FAIL flush_wc: got %0d want 0", word_count); end
        n_checks++; if (bdo_data !== 32'h0) begin n_fail++; $display("FAIL flush_data: got %h want 0", bdo_data); end
        tick();
        n_checks++; if (fill !== 3'd0) begin n_fail++; $display("FAIL flush_push_ignored: got %0d want 0", fill); end
    endtask

    task automatic test_async_reset;
        bdo_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(32'hE0000000 + 32'(i), 3'd4, 1'b0, 1'b0);
            tick();
        end
        idle_in();
        n_checks++; if (fill !== 3'd3) begin n_fail++; $display("FAIL ar_pre_fill: got %0d want 3", fill); end
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (bdo_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid_immediate: got %b want 0", bdo_valid); end
        n_checks++; if (fill !== 3'd0) begin n_fail++; $display("FAIL ar_fill_immediate: got %0d want 0", fill); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_in_ready: got %b want 1", in_ready); end
        n_checks++; if (bdo_data !== 32'h0) begin n_fail++; $display("FAIL ar_data: got %h want 0", bdo_data); end
        bdo_ready = 1'b1;
        drive(32'h0BADF00D, 3'd2, 1'b1, 1'b1);
        tick();
        idle_in();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ar_idle_to_drain: got %b want 0", in_ready); end
        n_checks++; if (bdo_data !== 32'h0BAD0000) begin n_fail++; $display("FAIL ar_new_word: got %h want 0bad0000", bdo_data); end
        tick();
    endtask

    task automatic test_zeroize;
        bdo_ready = 1'b1;
        drive(32'h5A5A5A5A, 3'd4, 1'b0, 1'b0);
        tick();
        drive(32'hA5A5A5A5, 3'd4, 1'b1, 1'b1);
        tick();
        idle_in();
        tick();
        n_checks++; if (bdo_valid !== 1'b0) begin n_fail++; $display("FAIL zz_valid: got %b want 0", bdo_valid); end
        n_checks++; if (bdo_last !== 1'b0 || bdo_is_tag !== 1'b0) begin n_fail++; $display("FAIL zz_flags: got last=%b tag=%b want 0 0", bdo_last, bdo_is_tag); end
`ifdef SPOC_BDO_ZEROIZE_EN
        n_checks++; if (bdo_data !== 32'h0) begin n_fail++; $display("FAIL zz_data: got %h want 0", bdo_data); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (dut.mem_q[i] !== '0) begin n_fail++; $display("FAIL zz_entry[%0d]: got %h want 0", i, dut.mem_q[i]); end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_masking();
        test_size_clamp();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_zeroize();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
